// File: rtl/simon_pkg.sv
// simon_pkg: shared widths and types for the Simon player-input path.
// Holds the button bus widths and the input controller state encoding.
package simon_pkg;

  localparam int BTN_W = 4;
  localparam int VAL_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_PRESS,
    ST_COMPARE,
    ST_DONE,
    ST_FAIL
  } in_state_t;

endpackage

// File: rtl/button_decoder.sv
// button_decoder: turns the raw button levels into a button number.
// valid is high only when exactly one button is down.
module button_decoder
  import simon_pkg::*;
(
  input  logic [BTN_W-1:0] btn,
  output logic             valid,
  output logic [VAL_W-1:0] val
);

  // one-hot detect and encode; anything else is not a press
  always_comb begin
    valid = 1'b1;
    val   = '0;
    case (btn)
      4'b0001: val = 2'd0;
      4'b0010: val = 2'd1;
      4'b0100: val = 2'd2;
      4'b1000: val = 2'd3;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/simon_input_ctrl.sv
// simon_input_ctrl: debounces player presses and checks them against
// the expected sequence, reporting round success, wrong press or timeout.
module simon_input_ctrl
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int MAX_LEN      = 32,
  parameter int IDX_W        = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   len,
  input  logic             abort,
  input  logic [BTN_W-1:0] btn,
  input  logic [VAL_W-1:0] exp_val,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             press,
  output logic [VAL_W-1:0] press_val,
  output logic             round_ok,
  output logic             round_fail,
  output logic             fail_timeout
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TM_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LEN_W = IDX_W + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  in_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TM_W-1:0]  tmr_q, tmr_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic [VAL_W-1:0] last_q, last_d;
  logic [VAL_W-1:0] pval_q, pval_d;
  logic             fto_q, fto_d;

  logic             dec_valid;
  logic [VAL_W-1:0] dec_val;
  logic             stable;
  logic [DB_W-1:0]  run;
  logic             timed_out;

  button_decoder u_dec (
    .btn   (btn),
    .valid (dec_valid),
    .val   (dec_val)
  );

  // samples already seen with the same value; a change restarts at 0
  assign stable    = dec_valid && (cnt_q != '0) && (dec_val == last_q);
  assign run       = stable ? cnt_q : '0;
  assign timed_out = (tmr_q == TM_LAST);

  // next-state, counters and latched values; abort wins over all
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pval_d  = pval_q;
    fto_d   = fto_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && len != '0) begin
            state_d = ST_ARM;
            len_d   = (len > LEN_MAX) ? LEN_MAX : len;
            idx_d   = '0;
            tmr_d   = '0;
            cnt_d   = '0;
            fto_d   = 1'b0;
          end
        end
        ST_ARM: begin
          tmr_d = tmr_q + 1'b1;
          if (timed_out) begin
            state_d = ST_FAIL;
            fto_d   = 1'b1;
          end else if (btn != '0) begin
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_WAIT_PRESS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_PRESS: begin
          tmr_d = tmr_q + 1'b1;
          if (timed_out) begin
            state_d = ST_FAIL;
            fto_d   = 1'b1;
          end else if (!dec_valid) begin
            cnt_d = '0;
          end else if (run == DB_LAST) begin
            state_d = ST_COMPARE;
            pval_d  = dec_val;
            cnt_d   = '0;
          end else begin
            cnt_d  = run + 1'b1;
            last_d = dec_val;
          end
        end
        ST_COMPARE: begin
          if (pval_q != exp_val) begin
            state_d = ST_FAIL;
            fto_d   = 1'b0;
          end else if ({1'b0, idx_q} == len_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ARM;
            idx_d   = idx_q + 1'b1;
            tmr_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_FAIL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      pval_q  <= '0;
      fto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pval_q  <= pval_d;
      fto_q   <= fto_d;
    end
  end

  assign idx          = idx_q;
  assign busy         = (state_q != ST_IDLE);
  assign press        = (state_q == ST_COMPARE);
  assign press_val    = pval_q;
  assign round_ok     = (state_q == ST_DONE);
  assign round_fail   = (state_q == ST_FAIL);
  assign fail_timeout = fto_q;

endmodule

// File: doc/simon_input_ctrl.md
# simon_input_ctrl

Player-input controller for the Simon game. It samples the four raw push-buttons through an internal `button_decoder` and debounces presses and releases. For each round it checks the player's sequence of presses, one element at a time, against the expected sequence memory, and reports round success, a wrong press or a timeout. It sits between the board buttons and the top-level game FSM, which starts it once per round and reads the result pulses.

## Interface
- `DEBOUNCE_CYC`, default 4: consecutive stable cycles required to accept a press or a release (must be ≥1).
- `TIMEOUT_CYC`, default 1000: maximum cycles allowed per element, from entering ARM to an accepted press.
- `MAX_LEN`, default 32: maximum round length.
- `IDX_W`, default $clog2(MAX_LEN): width of the sequence index.
- `clk` in 1: system clock. All state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: starts a round. Honoured only in IDLE and only when `len` ≠ 0.
- `len` in IDX_W+1: number of elements in the round. Values above MAX_LEN are clamped to MAX_LEN.
- `abort` in 1: synchronous return to IDLE from any state. No result pulse is produced.
- `btn` in 4: raw button levels, already synchronised to `clk` upstream.
- `exp_val` in 2: expected element at `idx`. Combinational read from the sequence memory.
- `idx` out IDX_W: current element index (sequence-memory address).
- `busy` out 1: high in every state except IDLE.
- `press` out 1: one-cycle pulse when a press is accepted.
- `press_val` out 2: value of the last accepted press. Held until the next accepted press.
- `round_ok` out 1: one-cycle pulse when all `len` elements have matched.
- `round_fail` out 1: one-cycle pulse on a wrong press or a timeout.
- `fail_timeout` out 1: qualifies `round_fail`. 1 = timeout, 0 = wrong value. Held until the next `start`.

## Operation
- Moore FSM states: IDLE, ARM, WAIT_PRESS, COMPARE, DONE, FAIL.
- Internal `button_decoder` produces `valid` (input is one-hot) and `val` (button number).
- IDLE:
  - On `start` with `len` ≠ 0: latch `len`, clear `idx`, clear the timer, go to ARM.
- ARM (release guard):
  - Requires `btn` == 0 for DEBOUNCE_CYC consecutive cycles, then goes to WAIT_PRESS.
  - Any nonzero `btn` clears the debounce counter.
- WAIT_PRESS:
  - Requires `valid` with an unchanged `val` for DEBOUNCE_CYC consecutive cycles. The debounce counter clears on `!valid` or on a change of `val`.
  - On acceptance: latch `press_val`, go to COMPARE.
- Timer:
  - Cleared on every entry to ARM.
  - Increments in ARM and WAIT_PRESS.
  - Reaching TIMEOUT_CYC-1 without an acceptance sends the FSM to FAIL with `fail_timeout` = 1.
  - Timeout has priority over a press accepted in the same cycle.
- COMPARE (one cycle, `press` = 1):
  - `press_val` ≠ `exp_val`: go to FAIL with `fail_timeout` = 0.
  - Match and `idx` == `len`-1: go to DONE.
  - Otherwise: increment `idx`, go to ARM.
- DONE: `round_ok` = 1 for one cycle, then IDLE.
- FAIL: `round_fail` = 1 for one cycle, then IDLE.
- `idx` holds its value in IDLE after a round so the game FSM can read the failing position. It is cleared on `start`.
- `start` while `busy` is ignored.
- `abort` has priority over every transition, including `start` in the same cycle.
- Reset values: state = IDLE; `idx`, timer and debounce counter = 0; `busy` = `press` = `round_ok` = `round_fail` = `fail_timeout` = 0; `press_val` = 0.

## Timing
- Release guard: from the first cycle `btn` == 0 is sampled in ARM (call it cycle T), the FSM is in WAIT_PRESS at cycle T+DEBOUNCE_CYC.
- Press: from the first stable one-hot sample in WAIT_PRESS (call it cycle P):
  - COMPARE (`press` high) at P+DEBOUNCE_CYC.
  - DONE, FAIL or ARM at P+DEBOUNCE_CYC+1.
- `round_ok` and `round_fail` are asserted on the cycle after COMPARE. `busy` drops on the following cycle.
- `exp_val` must be valid in the COMPARE cycle. `idx` is stable from entry to ARM until then.
- Asynchronous reset mid-round: all outputs take their reset values immediately, with no result pulse.

## Structure
- Package `simon_pkg`:
  - state enum for the FSM;
  - `BTN_W` = 4 and `VAL_W` = 2.
- Sub-module: the existing `button_decoder`, instantiated once on `btn`.
- Debounce counter and timeout timer stay inline as plain counters; a separate module is not warranted.

## Test plan
All scenarios use DEBOUNCE_CYC = 4 and TIMEOUT_CYC = 50.

1. Full match:
   - Stimulus: `len` = 3, memory = {0,2,3}; press 0001, 0100, 1000, each held 6 cycles, with releases of 6 cycles between them.
   - Required: `press` pulses with `press_val` = 0, 2, 3; then one `round_ok` pulse; `round_fail` never asserts.
2. Wrong value:
   - Stimulus: `len` = 2, memory = {1,1}; press 0010, then 0001.
   - Required: `round_fail` = 1 and `fail_timeout` = 0 one cycle after the second `press`; `idx` = 1.
3. Bounce rejection:
   - Stimulus: 0001 for 3 cycles, 0000 for 1 cycle, 0001 for 3 cycles, then 0001 stable.
   - Required: no `press` until 4 consecutive stable cycles have elapsed; exactly one `press`.
4. Invalid input:
   - Stimulus: 0011 or 1111 held 10 cycles.
   - Required: no `press`; the timer still runs.
5. Timeout, including a held button:
   - Stimulus: button held from `start`, or no input at all.
   - Required: `round_fail` = 1 and `fail_timeout` = 1 exactly 50 cycles after entering ARM.
6. Control edge cases:
   - Stimulus: `abort` mid-press; `start` with `len` = 0; `start` while `busy`; `rst_n` low mid-round.
   - Required:
     - `abort`: IDLE with no pulses.
     - `len` = 0: ignored, `busy` stays 0.
     - `start` while `busy`: ignored.
     - `rst_n` low: outputs return to reset values immediately.
